// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   FRAME_BITS     : bits per UART frame (start + 8 data + stop)
//   arb_state_t    : arbiter state encoding
//   recoverClocks(): length of the post-reset guard interval in clocks
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_RECOVER = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ACCEPT  = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT    = 3'd4
  } arb_state_t;

  // One full frame plus one clock, so a frame the transmitter was already
  // shifting when reset hit has certainly left the line.
  function automatic int recoverClocks(input int clocksPerBit);
    return FRAME_BITS * clocksPerBit + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   i_request : request vector, one bit per requester
//   i_pointer : index of the requester served last
//   o_grant   : one-hot winner, searching from i_pointer+1 modulo requesters
//   o_valid   : high when any request was found
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int requesters = 2,
  parameter int ptrWidth   = $clog2(requesters)
) (
  input  logic [requesters-1:0] i_request,
  input  logic [ptrWidth-1:0]   i_pointer,
  output logic [requesters-1:0] o_grant,
  output logic                  o_valid
);

  // Walk the candidates in priority order (pointer+1, pointer+2, ...) and
  // keep the first one that is requesting. Both loop bounds are constants,
  // so this unrolls into a small priority network.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= requesters; k++) begin
      for (int j = 0; j < requesters; j++) begin
        if (!o_valid && i_request[j] &&
            (((int'(i_pointer) + k) % requesters) == j)) begin
          o_grant[j] = 1'b1;
          o_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between several packet sources, granting a
// whole packet at a time in round-robin order.
//   clock, reset          : clock (posedge), asynchronous active-high reset
//   req_valid/data/last   : per-requester byte stream, requester i in
//                           req_data[8i+7:8i]
//   req_ready             : byte accepted when valid & ready
//   grant                 : one-hot current packet owner, zero when none
//   uart_send, uart_byte  : start pulse and byte for the transmitter
//   uart_done             : end-of-frame pulse from the transmitter
//   busy                  : arbiter not idle
//   aborted               : one-cycle pulse when a packet times out
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int requesters     = 2,
  parameter int clocks_per_bit = 1,
  parameter int timeout_clocks = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [requesters-1:0]   req_valid,
  input  logic [8*requesters-1:0] req_data,
  input  logic [requesters-1:0]   req_last,
  output logic [requesters-1:0]   req_ready,
  output logic [requesters-1:0]   grant,
  output logic                    uart_send,
  output logic [7:0]              uart_byte,
  input  logic                    uart_done,
  output logic                    busy,
  output logic                    aborted
);

  localparam int PTR_W          = $clog2(requesters);
  localparam int RECOVER_CLOCKS = recoverClocks(clocks_per_bit);
  localparam int RCW            = $clog2(RECOVER_CLOCKS + 1);
  localparam int TCW            = $clog2(timeout_clocks + 1);

  localparam logic [RCW-1:0]   RECOVER_LAST = RCW'(RECOVER_CLOCKS - 1);
  localparam logic [TCW-1:0]   TIMEOUT_LAST = TCW'(timeout_clocks - 1);
  localparam logic [PTR_W-1:0] PTR_RESET    = PTR_W'(requesters - 1);

  arb_state_t              r_state;
  arb_state_t              w_nextState;
  logic [PTR_W-1:0]        r_pointer;
  logic [requesters-1:0]   r_grant;
  logic [7:0]              r_byte;
  logic                    r_last;
  logic [RCW-1:0]          r_recoverCount;
  logic [TCW-1:0]          r_timeoutCount;

  logic [requesters-1:0]   w_pickGrant;
  logic                    w_pickValid;
  logic [PTR_W-1:0]        w_grantIdx;
  logic [7:0]              w_grantData;
  logic                    w_grantLast;
  logic                    w_grantValid;
  logic                    w_recoverDone;
  logic                    w_timeoutHit;

  rr_pick #(
    .requesters(requesters),
    .ptrWidth  (PTR_W)
  ) u_pick (
    .i_request(req_valid),
    .i_pointer(r_pointer),
    .o_grant  (w_pickGrant),
    .o_valid  (w_pickValid)
  );

  // Select the granted requester's lane. Only the owner's inputs are ever
  // looked at here, so other requesters cannot disturb a packet in flight.
  always_comb begin
    w_grantIdx   = '0;
    w_grantData  = '0;
    w_grantLast  = 1'b0;
    w_grantValid = 1'b0;
    for (int j = 0; j < requesters; j++) begin
      if (r_grant[j]) begin
        w_grantIdx   = PTR_W'(j);
        w_grantData  = req_data[8*j +: 8];
        w_grantLast  = req_last[j];
        w_grantValid = req_valid[j];
      end
    end
  end

  assign w_recoverDone = (r_recoverCount == RECOVER_LAST);
  assign w_timeoutHit  = (r_state == ST_ACCEPT) && !w_grantValid &&
                         (r_timeoutCount == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RECOVER;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. uart_done is only looked at in WAIT, so a stray pulse
  // anywhere else falls through to the hold default.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RECOVER: if (w_recoverDone) w_nextState = ST_IDLE;
      ST_IDLE:    if (w_pickValid)   w_nextState = ST_ACCEPT;
      ST_ACCEPT: begin
        if (w_grantValid)      w_nextState = ST_SEND;
        else if (w_timeoutHit) w_nextState = ST_IDLE;
      end
      ST_SEND:    w_nextState = ST_WAIT;
      ST_WAIT:    if (uart_done) w_nextState = r_last ? ST_IDLE : ST_ACCEPT;
      default:    w_nextState = ST_RECOVER;
    endcase
  end

  // Moore-style outputs decoded from the current state.
  always_comb begin
    req_ready = (r_state == ST_ACCEPT) ? r_grant : '0;
    uart_send = (r_state == ST_SEND);
    busy      = (r_state != ST_IDLE);
    aborted   = w_timeoutHit;
  end

  assign grant     = r_grant;
  assign uart_byte = r_byte;

  // Datapath: recovery and timeout counters, grant/pointer bookkeeping and
  // the byte latch. The timeout counter is zero whenever the state is not
  // ACCEPT, which clears it on every ACCEPT entry; accepting a byte leaves
  // ACCEPT, which clears it again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pointer      <= PTR_RESET;
      r_grant        <= '0;
      r_byte         <= '0;
      r_last         <= 1'b0;
      r_recoverCount <= '0;
      r_timeoutCount <= '0;
    end else begin
      r_recoverCount <= (r_state == ST_RECOVER) ? r_recoverCount + 1'b1 : '0;

      if ((r_state == ST_ACCEPT) && !w_grantValid && !w_timeoutHit) begin
        r_timeoutCount <= r_timeoutCount + 1'b1;
      end else begin
        r_timeoutCount <= '0;
      end

      if ((r_state == ST_IDLE) && w_pickValid) begin
        r_grant <= w_pickGrant;
      end else if ((w_nextState == ST_IDLE) &&
                   ((r_state == ST_ACCEPT) || (r_state == ST_WAIT))) begin
        r_pointer <= w_grantIdx;
        r_grant   <= '0;
      end

      if ((r_state == ST_ACCEPT) && w_grantValid) begin
        r_byte <= w_grantData;
        r_last <= w_grantLast;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench for uart_tx_arbiter. Packets are queued per requester,
// a packet-level round-robin model turns them into the expected sequence of
// (grant, byte) sends, and a monitor pops and compares on every uart_send.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int REQS           = 2;
  localparam int CPB            = 1;
  localparam int TIMEOUT        = 16;
  localparam int RECOVER_CLOCKS = 10 * CPB + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [REQS-1:0]   req_valid = '0;
  logic [8*REQS-1:0] req_data = '0;
  logic [REQS-1:0]   req_last = '0;
  logic [REQS-1:0]   req_ready;
  logic [REQS-1:0]   grant;
  logic              uart_send;
  logic [7:0]        uart_byte;
  logic              uart_done = 1'b0;
  logic              busy;
  logic              aborted;

  int checksTotal  = 0;
  int checksPassed = 0;
  int abortCount   = 0;
  int modelPtr     = REQS - 1;
  bit txAuto       = 1'b1;
  bit txPending    = 1'b0;
  logic prevSend   = 1'b0;

  logic [7:0] expByte[$];
  int         expGrant[$];
  logic [7:0] pendData[REQS][$];
  logic       pendLast[REQS][$];

  logic [7:0]      monByte;
  int              monIdx;
  logic [REQS-1:0] monGrant;
  logic [7:0]      txByte;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .requesters    (REQS),
    .clocks_per_bit(CPB),
    .timeout_clocks(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .uart_send(uart_send),
    .uart_byte(uart_byte),
    .uart_done(uart_done),
    .busy     (busy),
    .aborted  (aborted)
  );

  // One comparison: counts it and reports a failure with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // A bounded wait that ran out is itself a failed comparison.
  task automatic reportTimeout(input string name);
    checksTotal++;
    $display("[TB] FAIL %s: wait expired, expected the DUT to respond", name);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " grant"},     32'(grant),     32'd0);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, " uart_send"}, 32'(uart_send), 32'd0);
    checkOutput({tag, " uart_byte"}, 32'(uart_byte), 32'd0);
    checkOutput({tag, " aborted"},   32'(aborted),   32'd0);
    checkOutput({tag, " busy"},      32'(busy),      32'd1);
  endtask

  task automatic addByte(input int r, input logic [7:0] d, input logic l);
    pendData[r].push_back(d);
    pendLast[r].push_back(l);
  endtask

  task automatic addPacket(input int r, input int len);
    for (int i = 0; i < len; i++) addByte(r, 8'($urandom_range(0, 255)), i == len - 1);
  endtask

  // Packet-level reference: every requester with queued packets is
  // requesting whenever the arbiter is idle, so service order is plain
  // round-robin over non-empty queues, one whole packet per turn.
  task automatic computeExpected();
    logic [7:0] md[REQS][$];
    logic       ml[REQS][$];
    int pick;
    bit found;
    logic l;
    for (int r = 0; r < REQS; r++) begin
      md[r] = pendData[r];
      ml[r] = pendLast[r];
    end
    for (int guard = 0; guard < 1000; guard++) begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= REQS; k++) begin
        if (!found && md[(modelPtr + k) % REQS].size() > 0) begin
          found = 1'b1;
          pick  = (modelPtr + k) % REQS;
        end
      end
      if (!found) break;
      do begin
        expByte.push_back(md[pick].pop_front());
        expGrant.push_back(pick);
        l = ml[pick].pop_front();
      end while (!l && md[pick].size() > 0);
      modelPtr = pick;
    end
  endtask

  // Drives one requester's queued bytes. Random gaps are inserted only
  // between bytes of the same packet, while that requester owns the grant.
  task automatic applyStimulus(input int r);
    logic [7:0] d;
    logic l;
    bit midPacket = 1'b0;
    int n;
    while (pendData[r].size() > 0) begin
      d = pendData[r].pop_front();
      l = pendLast[r].pop_front();
      if (midPacket) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clock);
          #1;
        end
      end
      req_data[8*r +: 8] = d;
      req_last[r]        = l;
      req_valid[r]       = 1'b1;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!req_ready[r] && n < 4000);
      if (!req_ready[r]) begin
        reportTimeout($sformatf("requester %0d handshake", r));
        req_valid[r] = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
      req_valid[r] = 1'b0;
      midPacket = !l;
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || expByte.size() != 0 || txPending) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) reportTimeout(name);
    @(negedge clock);
  endtask

  task automatic runPackets(input string name);
    computeExpected();
    fork
      applyStimulus(0);
      applyStimulus(1);
    join
    waitIdle(name);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    modelPtr = REQS - 1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every send must match the next expected byte and
  // owner, and uart_send must never last two cycles.
  always @(negedge clock) begin
    if (uart_send) begin
      checkOutput("send single-cycle", 32'(prevSend), 32'd0);
      if (expByte.size() == 0) begin
        checksTotal++;
        $display("[TB] FAIL unexpected send: got byte 0x%0h, expected no send", uart_byte);
      end else begin
        monByte  = expByte.pop_front();
        monIdx   = expGrant.pop_front();
        monGrant = '0;
        monGrant[monIdx] = 1'b1;
        checkOutput("send byte",  32'(uart_byte), 32'(monByte));
        checkOutput("send grant", 32'(grant),     32'(monGrant));
      end
    end
    if (aborted) abortCount++;
    prevSend = uart_send;
  end

  // Transmitter model: answers each send with uart_done a few cycles later
  // and checks the byte was held for the whole frame.
  initial begin
    forever begin
      @(negedge clock);
      if (txAuto && uart_send) begin
        txByte    = uart_byte;
        txPending = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clock);
        checkOutput("byte stable in frame", 32'(uart_byte), 32'(txByte));
        uart_done = 1'b1;
        @(negedge clock);
        uart_done = 1'b0;
        txPending = 1'b0;
      end
    end
  end

  initial begin
    int readyAt;
    int sendAt;
    int readyCount;
    int abortAt;
    int abortsBefore;
    int n;
    bit ready0Seen;

    // Reset values, then the first send after the recovery guard.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    req_data[7:0] = 8'hA5;
    req_last[0]   = 1'b1;
    req_valid[0]  = 1'b1;
    expByte.push_back(8'hA5);
    expGrant.push_back(0);
    reset = 1'b0;
    readyAt = 0;
    sendAt  = 0;
    for (int c = 1; c <= 60 && sendAt == 0; c++) begin
      @(negedge clock);
      if (req_ready[0] && readyAt == 0) readyAt = c;
      if (uart_send) begin
        sendAt = c;
        req_valid[0] = 1'b0;
      end
    end
    checkOutput("first ready cycle", 32'(readyAt), 32'(RECOVER_CLOCKS + 1));
    checkOutput("first send cycle",  32'(sendAt),  32'(RECOVER_CLOCKS + 2));
    waitIdle("first packet");
    modelPtr = 0;

    // Two 2-byte packets from a fresh reset: requester 0 goes first.
    applyReset();
    addByte(0, 8'h11, 1'b0);
    addByte(0, 8'h12, 1'b1);
    addByte(1, 8'h21, 1'b0);
    addByte(1, 8'h22, 1'b1);
    runPackets("two packets");

    // Both backlogged: grants alternate packet by packet.
    for (int p = 0; p < 3; p++) addPacket(0, $urandom_range(1, 3));
    for (int p = 0; p < 2; p++) addPacket(1, $urandom_range(1, 3));
    runPackets("alternation");

    // A lone requester with back-to-back packets is regranted.
    for (int p = 0; p < 3; p++) addPacket(1, $urandom_range(1, 4));
    runPackets("single requester");

    // Random mixes of packet counts and lengths.
    for (int round = 0; round < 8; round++) begin
      for (int r = 0; r < REQS; r++) begin
        repeat ($urandom_range(0, 3)) addPacket(r, $urandom_range(1, 4));
      end
      runPackets("random round");
    end

    // Mid-packet stall on requester 1 times out; requester 0 is served next.
    expByte.push_back(8'h31);
    expGrant.push_back(1);
    expByte.push_back(8'h44);
    expGrant.push_back(0);
    req_data[15:8] = 8'h31;
    req_last[1]    = 1'b0;
    req_valid[1]   = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready[1] && n < 200);
    if (!req_ready[1]) reportTimeout("timeout packet handshake");
    @(negedge clock);
    req_valid[1]  = 1'b0;
    req_data[7:0] = 8'h44;
    req_last[0]   = 1'b1;
    req_valid[0]  = 1'b1;
    readyCount = 0;
    abortAt    = 0;
    ready0Seen = 1'b0;
    for (int c = 0; c < TIMEOUT * 4 + 50 && abortAt == 0; c++) begin
      @(negedge clock);
      if (req_ready[1]) readyCount++;
      if (req_ready[0]) ready0Seen = 1'b1;
      if (aborted) abortAt = readyCount;
    end
    checkOutput("abort after stalled ACCEPT cycles", 32'(abortAt), 32'(TIMEOUT));
    checkOutput("other ready while locked", 32'(ready0Seen), 32'd0);
    @(negedge clock);
    checkOutput("abort single pulse", 32'(aborted), 32'd0);
    n = 0;
    while (!uart_send && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!uart_send) reportTimeout("send after abort");
    req_valid[0] = 1'b0;
    waitIdle("after abort");
    modelPtr = 0;

    // uart_done while idle must not wake the arbiter.
    @(negedge clock);
    uart_done = 1'b1;
    @(negedge clock);
    uart_done = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle after stray done busy", 32'(busy),  32'd0);
    checkOutput("idle after stray done grant", 32'(grant), 32'd0);

    // Reset during WAIT drops the packet silently and re-runs recovery.
    txAuto = 1'b0;
    expByte.push_back(8'h5A);
    expGrant.push_back(0);
    req_data[7:0] = 8'h5A;
    req_last[0]   = 1'b1;
    req_valid[0]  = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!uart_send && n < 100);
    if (!uart_send) reportTimeout("send before reset");
    @(negedge clock);
    abortsBefore = abortCount;
    reset = 1'b1;
    @(negedge clock);
    checkResetValues("reset in WAIT");
    modelPtr = REQS - 1;
    expByte.push_back(8'h5A);
    expGrant.push_back(0);
    txAuto = 1'b1;
    reset  = 1'b0;
    sendAt = 0;
    for (int c = 1; c <= 60 && sendAt == 0; c++) begin
      @(negedge clock);
      if (uart_send) begin
        sendAt = c;
        req_valid[0] = 1'b0;
      end
    end
    checkOutput("send cycle after reset in WAIT", 32'(sendAt), 32'(RECOVER_CLOCKS + 2));
    waitIdle("after reset in WAIT");
    checkOutput("no abort from reset", 32'(abortCount - abortsBefore), 32'd0);
    checkOutput("total abort pulses", 32'(abortCount), 32'd1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter requesters, default 2, meaning the number of packet sources sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter clocks_per_bit, default 1, meaning the bit period of the attached transmitter in clocks.
REQ-003 SHALL have parameter timeout_clocks, default 1024, meaning the maximum wait for a mid-packet byte before abort.
REQ-004 SHALL have port clock  in  1  the single clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  requesters  per-requester byte available.
REQ-007 SHALL have port req_data  in  8*requesters  per-requester byte; requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_last  in  requesters  byte is the final byte of its packet.
REQ-009 SHALL have port req_ready  out  requesters  byte accepted when valid&ready.
REQ-010 SHALL have port grant  out  requesters  one-hot owner of the transmitter, zero when none.
REQ-011 SHALL have port uart_send  out  1  start pulse to the transmitter.
REQ-012 SHALL have port uart_byte  out  8  byte presented to the transmitter.
REQ-013 SHALL have port uart_done  in  1  one-cycle end-of-frame pulse from the transmitter.
REQ-014 SHALL have port busy  out  1  arbiter not in IDLE.
REQ-015 SHALL have port aborted  out  1  one-cycle pulse on packet timeout.

Function
REQ-016 SHALL implement states RECOVER, IDLE, ACCEPT, SEND, WAIT.
REQ-017 RECOVER SHALL hold for 10*clocks_per_bit+1 clocks, then go to IDLE (guards a frame the transmitter may still be shifting).
REQ-018 IDLE: if any req_valid, SHALL register grant to the first valid requester searching from pointer+1 modulo requesters, and go to ACCEPT; otherwise stay.
REQ-019 ACCEPT: req_ready SHALL be high only for the granted requester; on valid&ready, latch req_data into uart_byte, latch req_last, go to SEND.
REQ-020 SEND: uart_send SHALL be high for exactly this one cycle, then go to WAIT.
REQ-021 WAIT: on uart_done, go to IDLE if latched last, else ACCEPT keeping the same grant.
REQ-022 uart_byte SHALL remain stable from latch until the uart_done that ends that frame.
REQ-023 Grant SHALL be packet-locked: no other requester is served until the granted packet's last byte completes or aborts.
REQ-024 On leaving for IDLE, the pointer SHALL update to the granted index; grant clears to zero.
REQ-025 Latency: valid in IDLE cycle t -> ready at t+1 -> uart_send at t+2.
REQ-026 A timeout counter SHALL count consecutive ACCEPT cycles with granted req_valid low; at timeout_clocks, pulse aborted, advance pointer, go to IDLE.
REQ-027 The timeout counter SHALL clear on every ACCEPT entry and every accepted byte.
REQ-028 req_valid changes of non-granted requesters SHALL have no effect outside IDLE.
REQ-029 uart_done outside WAIT SHALL be ignored.
REQ-030 A single requester with back-to-back packets SHALL be regranted when it is the only valid one.

Reset
REQ-031 Reset SHALL force state RECOVER, pointer = requesters-1 (requester 0 first), grant=0, req_ready=0, uart_send=0, uart_byte=0, aborted=0, busy=1, counters 0.
REQ-032 Reset asserted mid-packet SHALL drop the packet silently (no aborted pulse) and re-run RECOVER.

Structure
REQ-033 State encoding and the frame length constant (10 bits) SHALL live in shared package uart_pkg.
REQ-034 Round-robin selection SHALL be one combinational sub-module rr_pick (request vector, pointer -> one-hot grant, valid).

Verification
REQ-035 After reset release, req_valid[0]=1 held: no uart_send for 11 clocks (clocks_per_bit=1), then send of req_data[7:0].
REQ-036 Both requesters valid with 2-byte packets 0x11,0x12 and 0x21,0x22: uart_byte sequence 0x11,0x12,0x21,0x22, one uart_send per byte.
REQ-037 Requester 0 continuously valid, requester 1 valid: grants alternate 0,1,0,1 by packet.
REQ-038 Requester 1 sends non-last byte then drops valid: aborted pulses exactly timeout_clocks ACCEPT cycles later, next grant goes to requester 0.
REQ-039 Reset asserted during WAIT: all outputs at reset values next cycle, aborted stays 0, RECOVER re-entered.
REQ-040 uart_done pulsed while IDLE: no state change, no uart_send.
